axi_master: RTL and testbench
=============================

# axi_master

Single-outstanding AXI4 initiator that converts a simple command/data stream interface into INCR burst transactions on an `axi4_if`. It is the initiator counterpart of `axi_slave`: it drives the AW/W/AR channels and consumes B/R, so example systems can be closed master-to-slave. Exactly one transaction (read or write) is in flight at a time. Results are returned on a response stream.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width; must equal the connected `axi4_if` address width
- DATA_WIDTH, 32, data width (32/64/128); must equal the interface data width
- ID_WIDTH, 4, ID width; must equal the interface ID width

Ports:
- clk  input  1  clock; everything is sampled on its rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  start byte address; must be size-aligned
- cmd_len  input  8  AXI LEN (beats - 1), 0..255
- cmd_id  input  ID_WIDTH  transaction ID
- wd_valid  input  1  write-data beat present
- wd_ready  output  1  write-data beat accepted
- wd_data  input  DATA_WIDTH  write-data beat
- rd_valid  output  1  read-data beat present
- rd_ready  input  1  read-data beat consumed
- rd_data  output  DATA_WIDTH  read-data beat
- rd_last  output  1  final beat of the burst
- rsp_valid  output  1  completion present
- rsp_ready  input  1  completion consumed
- rsp_write  output  1  completion belongs to a write
- rsp_resp  output  2  aggregated AXI response
- rsp_id  output  ID_WIDTH  ID of the completed transaction
- aw_1  axi4_if.aw_master  write address channel
- w_1  axi4_if.w_master  write data channel
- b_1  axi4_if.b_master  write response channel
- ar_1  axi4_if.ar_master  read address channel
- r_1  axi4_if.r_master  read data channel

## Operation
- FSM states: IDLE, AW, W, B, AR, R, RSP.
- IDLE:
  - cmd_ready=1.
  - On acceptance, latch write, addr, len and id, and clear the beat counter and the response accumulator.
  - Go to AW if cmd_write, else AR.
- AW: AWVALID=1 with AWADDR, AWLEN, AWID, AWSIZE=log2(DATA_WIDTH/8), AWBURST=INCR (01), all other AW fields 0. On AWREADY go to W.
- W:
  - WVALID=wd_valid, wd_ready=WREADY, WDATA=wd_data, WSTRB all ones, WLAST=(beat counter==len).
  - The counter increments on each W handshake.
  - The handshake with WLAST goes to B.
  - WVALID is never asserted before the AW handshake completes.
- B: BREADY=1. On BVALID capture BRESP and go to RSP. BID is not checked.
- AR: same pattern as AW using the AR fields. On ARREADY go to R.
- R:
  - RREADY=rd_ready, rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST. This is a combinational pass-through with no buffering.
  - Each beat folds RRESP into the accumulator: the first non-OKAY value is kept and later beats do not overwrite it.
  - The handshake with RLAST goes to RSP. Beats are not counted on reads; RLAST alone ends the burst.
- RSP:
  - rsp_valid=1; rsp_write, rsp_resp and rsp_id are held from the latched transaction.
  - On rsp_ready go to IDLE.
- 4 KB boundary crossing is not checked. The caller must not issue commands that cross it.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State=IDLE.
  - Registered outputs clear: AWVALID, ARVALID, rsp_valid and all latched fields go to 0.
  - Combinational outputs take their IDLE values: cmd_ready=1; WVALID, BREADY, RREADY, wd_ready and rd_valid are 0.
  - A reset mid-burst abandons the transaction with no response.
- AWVALID and ARVALID are registered and stay asserted, with stable payload, until their handshake.
- Command accept to AWVALID/ARVALID high: 1 cycle.
- Address handshake to first W eligibility: 1 cycle, because W is entered on the next edge.
- B/R last handshake to rsp_valid: 1 cycle.
- rsp handshake to cmd_ready: 1 cycle. Back-to-back throughput is therefore limited by the single outstanding transaction.
- RSP state with rsp_ready held 0: rsp_valid and its payload are held indefinitely, and no new command is accepted.
- len=0: a single beat with WLAST=1 on the first W handshake.

## Test plan
- Write, addr 0x100, len 0, id 3, data 0xDEADBEEF, slave always ready, BRESP=OKAY:
  - AW shows addr 0x100, LEN 0, SIZE 2, BURST 01.
  - One W beat with WLAST=1 and WSTRB=0xF.
  - Response: rsp_write=1, rsp_resp=0, rsp_id=3.
- Read, addr 0x2000, len 3, slave returns 0x0..0x3 with RRESP OKAY, OKAY, SLVERR, DECERR:
  - rd_data sequence is 0,1,2,3 with rd_last only on beat 4.
  - rsp_resp=2 (first non-OKAY wins).
- Backpressure:
  - AWREADY held 0 for 5 cycles: AWVALID and payload stay stable; wd_ready stays 0 throughout.
  - WREADY toggles every cycle on a len 7 write: exactly 8 beats, WLAST only on the 8th.
- rd_ready=0 for 4 cycles mid-burst: RREADY=0, no beat lost, data order preserved.
- rsp_ready=0 for 10 cycles with cmd_valid=1: rsp_valid held and cmd_ready=0 throughout. After rsp_ready=1, cmd_ready=1 on the next cycle.
- Reset asserted during W beat 2 of a len 3 write:
  - AWVALID, WVALID and rsp_valid drop asynchronously; cmd_ready=1 immediately.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/axi_master_if.sv
// rtl/axi_master_if.sv - AXI4 bus bundle shared by initiator and target
//
// Purpose: one AXI4 link, split into per-channel modports so a block can take
// only the channels it actually drives or consumes.
// Parameters: ADDR_WIDTH, DATA_WIDTH, ID_WIDTH
// Modports:
//   aw_master/w_master/ar_master : drive address/data payload + valid, read ready
//   b_master/r_master            : read response payload + valid, drive ready
//   *_slave                      : mirror images of the above

interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // write address
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    // write data
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // write response
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // read address
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    // read data
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport aw_master (output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                       input  awready);
    modport w_master  (output wdata, wstrb, wlast, wvalid, input wready);
    modport b_master  (input  bid, bresp, bvalid, output bready);
    modport ar_master (output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                       input  arready);
    modport r_master  (input  rid, rdata, rresp, rlast, rvalid, output rready);

    modport aw_slave  (input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
                       output awready);
    modport w_slave   (input  wdata, wstrb, wlast, wvalid, output wready);
    modport b_slave   (output bid, bresp, bvalid, input bready);
    modport ar_slave  (input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
                       output arready);
    modport r_slave   (output rid, rdata, rresp, rlast, rvalid, input rready);
endinterface

// File: rtl/axi_master.sv
// rtl/axi_master.sv - single-outstanding AXI4 INCR-burst initiator
//
// Purpose: turns a command stream (write/addr/len/id) plus a write-data stream
// into one AXI4 transaction at a time, passes read beats straight through and
// returns one completion per transaction on the response stream.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   cmd_*                 : command stream (valid/ready, write, addr, len, id)
//   wd_*                  : write-data beats in (valid/ready, data)
//   rd_*                  : read-data beats out (valid/ready, data, last)
//   rsp_*                 : completion out (valid/ready, write, resp, id)
//   aw_1/w_1/b_1/ar_1/r_1 : AXI4 channels, initiator side

module axi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [1:0]            rsp_resp,
    output logic [ID_WIDTH-1:0]   rsp_id,
    axi4_if.aw_master             aw_1,
    axi4_if.w_master              w_1,
    axi4_if.b_master              b_1,
    axi4_if.ar_master             ar_1,
    axi4_if.r_master              r_1
);
    localparam logic [2:0] AXSIZE     = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, RSP} state_t;

    state_t                state, next_state;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  rsp_valid_q;

    logic                  cmd_hs;
    logic                  w_hs;
    logic                  r_hs;
    logic                  wlast_c;

    assign cmd_hs  = (state == IDLE) && cmd_valid;
    assign w_hs    = (state == W) && wd_valid && w_1.wready;
    assign r_hs    = (state == R) && r_1.rvalid && rd_ready;
    assign wlast_c = (beat_cnt == len_q);

    // Address channels: payload comes straight from the latched command, so it
    // is stable for as long as the registered valid is held.
    assign aw_1.awvalid = awvalid_q;
    assign aw_1.awid    = id_q;
    assign aw_1.awaddr  = addr_q;
    assign aw_1.awlen   = len_q;
    assign aw_1.awsize  = AXSIZE;
    assign aw_1.awburst = BURST_INCR;
    assign aw_1.awlock  = 1'b0;
    assign aw_1.awcache = 4'd0;
    assign aw_1.awprot  = 3'd0;

    assign ar_1.arvalid = arvalid_q;
    assign ar_1.arid    = id_q;
    assign ar_1.araddr  = addr_q;
    assign ar_1.arlen   = len_q;
    assign ar_1.arsize  = AXSIZE;
    assign ar_1.arburst = BURST_INCR;
    assign ar_1.arlock  = 1'b0;
    assign ar_1.arcache = 4'd0;
    assign ar_1.arprot  = 3'd0;

    assign w_1.wdata = wd_data;
    assign w_1.wstrb = '1;
    assign w_1.wlast = wlast_c;

    assign rd_data = r_1.rdata;
    assign rd_last = r_1.rlast;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = write_q;
    assign rsp_resp  = resp_q;
    assign rsp_id    = id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            beat_cnt    <= '0;
            resp_q      <= RESP_OKAY;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        write_q   <= cmd_write;
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        id_q      <= cmd_id;
                        beat_cnt  <= '0;
                        resp_q    <= RESP_OKAY;
                        awvalid_q <= cmd_write;
                        arvalid_q <= !cmd_write;
                    end
                end
                AW: begin
                    if (aw_1.awready) awvalid_q <= 1'b0;
                end
                W: begin
                    if (w_hs) beat_cnt <= beat_cnt + 8'd1;
                end
                B: begin
                    if (b_1.bvalid) begin
                        resp_q      <= b_1.bresp;
                        rsp_valid_q <= 1'b1;
                    end
                end
                AR: begin
                    if (ar_1.arready) arvalid_q <= 1'b0;
                end
                R: begin
                    if (r_hs) begin
                        // Sticky: once an error is seen, later beats cannot mask it.
                        if (resp_q == RESP_OKAY) resp_q <= r_1.rresp;
                        if (r_1.rlast) rsp_valid_q <= 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state   = state;
        cmd_ready    = 1'b0;
        wd_ready     = 1'b0;
        w_1.wvalid   = 1'b0;
        b_1.bready   = 1'b0;
        r_1.rready   = 1'b0;
        rd_valid     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = cmd_write ? AW : AR;
            end
            AW: begin
                if (aw_1.awready) next_state = W;
            end
            W: begin
                // Only reachable after the AW handshake, so W can never lead AW.
                w_1.wvalid = wd_valid;
                wd_ready   = w_1.wready;
                if (w_hs && wlast_c) next_state = B;
            end
            B: begin
                b_1.bready = 1'b1;
                if (b_1.bvalid) next_state = RSP;
            end
            AR: begin
                if (ar_1.arready) next_state = R;
            end
            R: begin
                r_1.rready = rd_ready;
                rd_valid   = r_1.rvalid;
                if (r_hs && r_1.rlast) next_state = RSP;
            end
            RSP: begin
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_master.sv
// tb/tb_axi_master.sv - directed self-checking bench for axi_master

module tb_axi_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_id = '0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [31:0] wd_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [1:0]  rsp_resp;
    logic [3:0]  rsp_id;

    int n_checks = 0;
    int n_fail   = 0;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .reset(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_resp(rsp_resp), .rsp_id(rsp_id),
        .aw_1(bus), .w_1(bus), .b_1(bus), .ar_1(bus), .r_1(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wpat(input int beat);
        return 32'hA500_0000 + 32'(beat);
    endfunction

    // Present a command, confirm it is taken, and confirm the address valid
    // rises one cycle later.
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] id);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        if (wr) begin
            check("awvalid_lat", bus.awvalid, 1);
            check("awaddr", bus.awaddr, addr);
            check("awlen", bus.awlen, len);
            check("awsize", bus.awsize, 2);
            check("awburst", bus.awburst, 1);
            check("awid", bus.awid, id);
        end else begin
            check("arvalid_lat", bus.arvalid, 1);
            check("araddr", bus.araddr, addr);
            check("arlen", bus.arlen, len);
            check("arsize", bus.arsize, 2);
            check("arburst", bus.arburst, 1);
            check("arid", bus.arid, id);
        end
    endtask

    // Completion check; optionally hold rsp_ready low with a competing command.
    task automatic finish_rsp(input logic wr, input logic [1:0] exp_resp, input logic [3:0] id,
                              input int hold);
        #1;
        check("rsp_valid_lat", rsp_valid, 1);
        check("rsp_write", rsp_write, wr);
        check("rsp_resp", rsp_resp, exp_resp);
        check("rsp_id", rsp_id, id);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 8'd0; cmd_id = 4'd9;
            #1;
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_resp", rsp_resp, exp_resp);
            check("rsp_hold_cmd_ready", cmd_ready, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        check("rsp_valid_at_hs", rsp_valid, 1);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        check("cmd_ready_after_rsp", cmd_ready, 1);
        check("rsp_valid_cleared", rsp_valid, 0);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [1:0] bresp, input int aw_stall, input bit wtoggle,
                             input int hold);
        int  beat = 0;
        int  cyc = 0;
        bit  aw_done = 0;
        bit  done = 0;
        wd_valid = 1'b1;
        wd_data  = wpat(0);
        issue_cmd(1'b1, addr, len, id);
        while (!done && cyc < 300) begin
            @(negedge clk);
            bus.awready = (cyc >= aw_stall);
            bus.wready  = wtoggle ? cyc[0] : 1'b1;
            wd_data     = wpat(beat);
            bus.bvalid  = (beat > int'(len));
            bus.bresp   = bresp;
            #1;
            if (!aw_done) begin
                check("aw_hold_valid", bus.awvalid, 1);
                check("aw_hold_addr", bus.awaddr, addr);
                check("aw_hold_len", bus.awlen, len);
                check("wvalid_before_aw", bus.wvalid, 0);
                check("wd_ready_before_aw", wd_ready, 0);
            end
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) begin
                check("wdata", bus.wdata, wpat(beat));
                check("wstrb", bus.wstrb, 4'hF);
                check("wlast", bus.wlast, beat == int'(len));
                check("wd_ready_pass", wd_ready, 1);
                beat++;
            end
            if (bus.bvalid && bus.bready) done = 1;
            cyc++;
        end
        if (!done) check("write_timeout", 0, 1);
        check("write_beats", beat, int'(len) + 1);
        @(negedge clk);
        bus.bvalid = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0; wd_valid = 1'b0;
        finish_rsp(1'b1, bresp, id, hold);
    endtask

    // rresp_v packs two bits per beat, beat 0 in the low bits.
    task automatic read_txn(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input logic [15:0] rresp_v, input logic [1:0] exp_resp,
                            input int stall_lo, input int stall_hi);
        int  beat = 0;
        int  cyc = 0;
        bit  ar_done = 0;
        bit  done = 0;
        bit  stalled;
        rd_ready = 1'b1;
        issue_cmd(1'b0, addr, len, id);
        while (!done && cyc < 300) begin
            @(negedge clk);
            stalled     = (cyc >= stall_lo) && (cyc < stall_hi);
            bus.arready = 1'b1;
            bus.rvalid  = ar_done && (beat <= int'(len));
            bus.rdata   = 32'(beat);
            bus.rresp   = rresp_v[2*beat +: 2];
            bus.rlast   = (beat == int'(len));
            rd_ready    = !stalled;
            #1;
            if (bus.arvalid && bus.arready) ar_done = 1;
            if (bus.rvalid) begin
                check("rd_valid_pass", rd_valid, 1);
                check("rready_pass", bus.rready, !stalled);
            end
            if (bus.rvalid && bus.rready) begin
                check("rd_data", rd_data, beat);
                check("rd_last", rd_last, beat == int'(len));
                if (bus.rlast) done = 1;
                beat++;
            end
            cyc++;
        end
        if (!done) check("read_timeout", 0, 1);
        check("read_beats", beat, int'(len) + 1);
        @(negedge clk);
        bus.rvalid = 1'b0; bus.arready = 1'b0; rd_ready = 1'b0;
        finish_rsp(1'b0, exp_resp, id, 0);
    endtask

    initial begin
        bus.awready = 1'b0; bus.wready = 1'b0;
        bus.bvalid = 1'b0; bus.bresp = 2'd0; bus.bid = 4'd0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'd0; bus.rlast = 1'b0; bus.rid = 4'd0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single-beat write
        bus.wready = 1'b1;
        write_txn(32'h100, 8'd0, 4'd3, 2'b00, 0, 1'b0, 0);
        // OKAY, OKAY, SLVERR, DECERR -> SLVERR sticks
        read_txn(32'h2000, 8'd3, 4'd1, 16'b0000_0000_1110_0000, 2'b10, 1000, 1000);
        // AW stall, toggling WREADY, len 7, long-held response with competing command
        write_txn(32'h300, 8'd7, 4'd5, 2'b10, 5, 1'b1, 10);
        // rd_ready low for 4 cycles mid-burst
        read_txn(32'h400, 8'd7, 4'd6, 16'h0000, 2'b00, 3, 7);

        // reset during W beat 2 of a len 3 write
        wd_valid = 1'b1; wd_data = wpat(0);
        bus.awready = 1'b1; bus.wready = 1'b1;
        issue_cmd(1'b1, 32'h500, 8'd3, 4'd7);
        repeat (3) @(negedge clk);
        #1;
        check("pre_rst_wvalid", bus.wvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_awvalid", bus.awvalid, 0);
        check("arst_wvalid", bus.wvalid, 0);
        check("arst_wd_ready", wd_ready, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        bus.awready = 1'b0; bus.wready = 1'b0; wd_valid = 1'b0;
        rst_n = 1'b1;
        // OKAY then EXOKAY
        read_txn(32'h600, 8'd1, 4'd2, 16'b0000_0000_0000_0100, 2'b01, 1000, 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
